// File: rtl/priority_encoder_83.sv
// ============================================================================
//  Module      : priority_encoder_83
//  Description : Registered 8-to-3 priority encoder with sticky request capture
//                and a valid/ack handshake that frees the served request.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_encoder_83 #(
  parameter bit EDGE_MODE  = 1'b0,
  parameter bit PRIO_HIGH7 = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pending,
  output logic       busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic [7:0] pending_q, pending_d;
  logic       busy_q, busy_d;

  logic [7:0] cap;
  logic [7:0] clr;
  logic [7:0] elig;
  logic [2:0] pick;

  // Later assignment wins, so the loop direction selects the priority end.
  function automatic logic [2:0] f_pick(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (PRIO_HIGH7) begin
        if (v[i]) idx = 3'(i);
      end else begin
        if (v[7-i]) idx = 3'(7 - i);
      end
    end
    return idx;
  endfunction

  generate
    if (EDGE_MODE) begin : g_edge
      logic [7:0] req_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          req_q <= '0;
        end else begin
          req_q <= req;
        end
      end
      assign cap = req & ~req_q;
    end else begin : g_level
      assign cap = req;
    end
  endgenerate

  assign elig = pending_q & mask;
  assign pick = f_pick(elig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (elig != 8'h00) state_d = S_GRANT;
      S_GRANT: if (ack)           state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    clr     = '0;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (elig != 8'h00) begin
          code_d  = pick;
          valid_d = 1'b1;
        end
      end
      S_GRANT: begin
        valid_d = 1'b1;
        if (ack) begin
          clr       = 8'h01 << code_q;
          valid_d   = 1'b0;
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  // A fresh capture overrides the clear of the same bit.
  assign pending_d = (pending_q & ~clr) | cap;
  assign busy_d    = |(pending_d & mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q    <= '0;
      valid_q   <= 1'b0;
      pending_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      code_q    <= code_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_priority_encoder_83.sv
// ============================================================================
//  Module      : tb_priority_encoder_83
//  Description : Self-checking bench for three priority_encoder_83 variants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_priority_encoder_83;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack_l, ack_e, ack_p;
  logic [2:0] code_l, code_e, code_p;
  logic       valid_l, valid_e, valid_p;
  logic [7:0] pending_l, pending_e, pending_p;
  logic       busy_l, busy_e, busy_p;

  int n_tests = 0;
  int n_fail  = 0;
  bit auto_ack = 1'b0;

  priority_encoder_83 #(.EDGE_MODE(1'b0), .PRIO_HIGH7(1'b1)) u_lvl (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack_l),
    .code(code_l), .valid(valid_l), .pending(pending_l), .busy(busy_l));

  priority_encoder_83 #(.EDGE_MODE(1'b1), .PRIO_HIGH7(1'b1)) u_edg (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack_e),
    .code(code_e), .valid(valid_e), .pending(pending_e), .busy(busy_e));

  priority_encoder_83 #(.EDGE_MODE(1'b0), .PRIO_HIGH7(1'b0)) u_low (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack_p),
    .code(code_p), .valid(valid_p), .pending(pending_p), .busy(busy_p));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pend;
    logic [7:0] rprev;
    bit         gnt;
    logic [2:0] code;
    bit         busy;
  } mdl_t;

  mdl_t m_l, m_e, m_p;

  function automatic mdl_t mreset();
    mdl_t m;
    m.pend = '0; m.rprev = '0; m.gnt = 1'b0; m.code = '0; m.busy = 1'b0;
    return m;
  endfunction

  // One clock of the arbiter described as "serve, then collect new requests".
  function automatic mdl_t step(mdl_t m, logic [7:0] r, logic [7:0] mk, bit a,
                                bit edge_m, bit hi7);
    mdl_t n;
    logic [7:0] newreq;
    logic [7:0] cand;
    n = m;
    newreq = edge_m ? (r & ~m.rprev) : r;
    cand = m.pend & mk;
    if (m.gnt) begin
      if (a) begin
        n.pend[m.code] = 1'b0;
        n.gnt = 1'b0;
      end
    end else if (cand != 0) begin
      n.gnt = 1'b1;
      if (hi7) begin
        for (int i = 7; i >= 0; i--) if (cand[i]) begin n.code = 3'(i); break; end
      end else begin
        for (int i = 0; i < 8; i++) if (cand[i]) begin n.code = 3'(i); break; end
      end
    end
    n.pend  = n.pend | newreq;
    n.busy  = (n.pend & mk) != 0;
    n.rprev = r;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_one(input string nm, input mdl_t m, input logic [2:0] c,
                         input logic v, input logic [7:0] p, input logic b);
    chk({nm, ".code"},    {5'b0, c}, {5'b0, m.code});
    chk({nm, ".valid"},   {7'b0, v}, {7'b0, m.gnt});
    chk({nm, ".pending"}, p,         m.pend);
    chk({nm, ".busy"},    {7'b0, b}, {7'b0, m.busy});
  endtask

  task automatic chk_all();
    chk_one("lvl", m_l, code_l, valid_l, pending_l, busy_l);
    chk_one("edg", m_e, code_e, valid_e, pending_e, busy_e);
    chk_one("low", m_p, code_p, valid_p, pending_p, busy_p);
  endtask

  task automatic set_ack(input bit a);
    ack_l = a; ack_e = a; ack_p = a;
  endtask

  task automatic cyc();
    if (auto_ack) begin
      ack_l = m_l.gnt; ack_e = m_e.gnt; ack_p = m_p.gnt;
    end
    @(posedge clk);
    if (!rst_n) begin
      m_l = mreset(); m_e = mreset(); m_p = mreset();
    end else begin
      m_l = step(m_l, req, mask, ack_l, 1'b0, 1'b1);
      m_e = step(m_e, req, mask, ack_e, 1'b1, 1'b1);
      m_p = step(m_p, req, mask, ack_p, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk_all();
  endtask

  // Reset dropped between edges must clear outputs without a clock.
  task automatic areset();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", {5'b0, valid_l, valid_e, valid_p}, 8'h00);
    chk("arst.pend_l", pending_l, 8'h00);
    chk("arst.pend_e", pending_e, 8'h00);
    chk("arst.busy", {5'b0, busy_l, busy_e, busy_p}, 8'h00);
    m_l = mreset(); m_e = mreset(); m_p = mreset();
    @(negedge clk);
    chk_all();
    rst_n = 1'b1;
  endtask

  task automatic sreset();
    rst_n = 1'b0; req = '0; mask = 8'hFF; set_ack(1'b0); auto_ack = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt_l, cnt_e;
    bit pv_l, pv_e;
    m_l = mreset(); m_e = mreset(); m_p = mreset();
    rst_n = 1'b0; req = 8'hFF; mask = 8'hFF; set_ack(1'b0);
    @(negedge clk);

    // T1: reset with all requests high, then first grant two edges later
    repeat (2) cyc();
    chk("t1.rst_code", {5'b0, code_l}, 8'h00);
    chk("t1.rst_pend", pending_l, 8'h00);
    rst_n = 1'b1;
    cyc();
    chk("t1.e1_valid", {7'b0, valid_l}, 8'h00);
    cyc();
    chk("t1.e2_valid", {7'b0, valid_l}, 8'h01);
    chk("t1.e2_code", {5'b0, code_l}, 8'h07);
    chk("t1.low_code", {5'b0, code_p}, 8'h00);

    // T2: two requests in one pulse, served in priority order with a bubble
    sreset();
    req = 8'b0010_0100; cyc(); req = 8'h00; cyc();
    chk("t2.first", {5'b0, code_l}, 8'h05);
    set_ack(1'b1); cyc();
    chk("t2.bubble", {7'b0, valid_l}, 8'h00);
    set_ack(1'b0); cyc();
    chk("t2.second", {5'b0, code_l}, 8'h02);
    set_ack(1'b1); cyc(); set_ack(1'b0); cyc();
    chk("t2.drained_v", {7'b0, valid_l}, 8'h00);
    chk("t2.drained_p", pending_l, 8'h00);

    // T3: code frozen while a higher request arrives
    req = 8'h04; cyc(); req = 8'h00; cyc();
    req = 8'h80; cyc(); req = 8'h00; cyc(); cyc();
    chk("t3.frozen", {5'b0, code_l}, 8'h02);
    set_ack(1'b1); cyc(); set_ack(1'b0); cyc();
    chk("t3.next", {5'b0, code_l}, 8'h07);
    set_ack(1'b1); cyc(); set_ack(1'b0); cyc();

    // T4: masked request persists until its mask opens
    sreset();
    mask = 8'h01; req = 8'h81; cyc(); req = 8'h00; cyc();
    chk("t4.code0", {5'b0, code_l}, 8'h00);
    set_ack(1'b1); cyc(); set_ack(1'b0);
    chk("t4.keep7", pending_l, 8'h80);
    chk("t4.busy0", {7'b0, busy_l}, 8'h00);
    cyc(); cyc();
    mask = 8'hFF; cyc(); cyc();
    chk("t4.code7", {5'b0, code_l}, 8'h07);
    chk("t4.valid", {7'b0, valid_l}, 8'h01);

    // T5: held request, ack tied to valid
    sreset();
    auto_ack = 1'b1; cnt_l = 0; cnt_e = 0; pv_l = 1'b0; pv_e = 1'b0;
    for (int i = 0; i < 14; i++) begin
      req = (i < 10) ? 8'h08 : 8'h00;
      cyc();
      if (valid_l && !pv_l) cnt_l++;
      if (valid_e && !pv_e) cnt_e++;
      pv_l = valid_l; pv_e = valid_e;
    end
    chk("t5.edge_grants", 8'(cnt_e), 8'd1);
    chk("t5.level_grants", 8'(cnt_l), 8'd5);
    auto_ack = 1'b0; set_ack(1'b0);

    // T6: ack coincides with a new rising edge of the served request
    sreset();
    req = 8'h08; cyc(); req = 8'h00; cyc();
    chk("t6.grant3", {5'b0, code_e}, 8'h03);
    req = 8'h08; set_ack(1'b1); cyc();
    chk("t6.set_wins", pending_e, 8'h08);
    req = 8'h00; set_ack(1'b0); cyc();
    chk("t6.regrant", {4'b0, valid_e, code_e}, 8'h0B);
    // ack with no live grant
    sreset();
    mask = 8'h00; req = 8'h01; cyc(); req = 8'h00;
    set_ack(1'b1); cyc(); cyc();
    chk("t6.ack_idle_p", pending_l, 8'h01);
    chk("t6.ack_idle_v", {7'b0, valid_l}, 8'h00);
    set_ack(1'b0); mask = 8'hFF; cyc();
    chk("t6.late", {4'b0, valid_l, code_l}, 8'h08);
    areset();

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        areset();
      end else begin
        req  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
        mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
        auto_ack = ($urandom_range(0, 1) == 1);
        if (!auto_ack) begin
          ack_l = 1'($urandom); ack_e = 1'($urandom); ack_p = 1'($urandom);
        end
        cyc();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
